// File: rtl/pi_result_reader_pkg.sv
// Shared types and constants for the pi result reader.
// Holds the FSM state enum, the Q2.6 saturation value and the divider length formula.
package pi_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL_TOT,
        CAP_TOT,
        SEL_HIT,
        CAP_HIT,
        DIV,
        HOLD
    } state_e;

    localparam logic [7:0] Q26_SAT = 8'hFF;

    // Quotient width and divider cycle count: 8 hit bits plus the shift.
    function automatic int div_cycles(input int total_shift);
        return 8 + total_shift;
    endfunction

    localparam int DIV_N_DEFAULT = div_cycles(7);

endpackage

// File: rtl/pi_result_reader_if.sv
// Estimator bus and result handshake bundle for pi_result_reader.
// master: reader side (drives sel/busy/result/result_valid/div_zero); slave: environment side.
interface pi_result_reader_if;

    logic       start;
    logic [7:0] bus_in;
    logic       sel;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       div_zero;

    modport master (
        input  start,
        input  bus_in,
        input  result_ready,
        output sel,
        output busy,
        output result,
        output result_valid,
        output div_zero
    );

    modport slave (
        output start,
        output bus_in,
        output result_ready,
        input  sel,
        input  busy,
        input  result,
        input  result_valid,
        input  div_zero
    );

endinterface

// File: rtl/pi_result_reader_div.sv
// pi_serial_div: N-cycle restoring divider, one quotient bit per cycle, MSB first.
// Ports: clk, rst, load_i, num_i[N], den_i[8] (held stable while running), done_o, quot_o[N].
module pi_serial_div #(
    parameter int N = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] num_i,
    input  logic [7:0]   den_i,
    output logic         done_o,
    output logic [N-1:0] quot_o
);

    localparam int CW = $clog2(N);

    logic          act_q, act_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rem_q, rem_d;
    // Numerator bits shift out the top while quotient bits shift in the bottom.
    logic [N-1:0]  sh_q, sh_d;

    logic [8:0] acc;
    logic [7:0] diff;
    logic       ge;

    assign acc  = {rem_q, sh_q[N-1]};
    assign ge   = acc >= {1'b0, den_i};
    // When ge holds the true difference is below den_i, so 8 bits suffice.
    assign diff = acc[7:0] - den_i;

    always_comb begin
        act_d = act_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        sh_d  = sh_q;
        if (load_i) begin
            act_d = 1'b1;
            cnt_d = '0;
            rem_d = '0;
            sh_d  = num_i;
        end else if (act_q) begin
            rem_d = ge ? diff : acc[7:0];
            sh_d  = {sh_q[N-2:0], ge};
            if (cnt_q == CW'(N - 1)) begin
                act_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            sh_q  <= '0;
        end else begin
            act_q <= act_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            sh_q  <= sh_d;
        end
    end

    // High in the cycle whose closing edge writes the last quotient bit.
    assign done_o = act_q && (cnt_q == CW'(N - 1));
    assign quot_o = sh_q;

endmodule

// File: rtl/pi_result_reader.sv
// pi_result_reader: snapshots the estimator counter bus and presents hits*2^TOTAL_SHIFT/total as Q2.6.
// Ports: clk, rst (sync, active high), io (pi_result_reader_if.master). Option: PI_READER_AUTO_EN.
module pi_result_reader
    import pi_reader_pkg::*;
#(
    parameter int SETTLE_CYC  = 2,
    parameter int TOTAL_SHIFT = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    pi_result_reader_if.master    io
);

    localparam int N = div_cycles(TOTAL_SHIFT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tot_q, tot_d;
    logic [7:0] res_q, res_d;
    logic       vld_q, vld_d;
    logic       dz_q, dz_d;

    logic         div_load;
    logic         div_done;
    logic [N-1:0] quot;
    logic [7:0]   sat_res;

    // The divider's shift register is the hit snapshot: it loads straight
    // from the bus on the CAP_HIT edge, so the divide starts without a gap.
    pi_serial_div #(.N(N)) u_div (
        .clk    (clk),
        .rst    (rst),
        .load_i (div_load),
        .num_i  ({io.bus_in, {TOTAL_SHIFT{1'b0}}}),
        .den_i  (tot_q),
        .done_o (div_done),
        .quot_o (quot)
    );

    assign sat_res = (|quot[N-1:8]) ? Q26_SAT : quot[7:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tot_d    = tot_q;
        res_d    = res_q;
        vld_d    = vld_q;
        dz_d     = dz_q;
        div_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef PI_READER_AUTO_EN
                state_d = SEL_TOT;
`else
                if (io.start) begin
                    state_d = SEL_TOT;
                end
`endif
            end
            SEL_TOT: begin
                if (cnt_q == 4'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = CAP_TOT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAP_TOT: begin
                tot_d   = io.bus_in;
                state_d = SEL_HIT;
            end
            SEL_HIT: begin
                if (cnt_q == 4'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = CAP_HIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CAP_HIT: begin
                if (tot_q != 8'd0) begin
                    div_load = 1'b1;
                    state_d  = DIV;
                end else begin
                    state_d = HOLD;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // First HOLD cycle registers the result; then wait for ready.
                if (!vld_q) begin
                    vld_d = 1'b1;
                    if (tot_q == 8'd0) begin
                        res_d = Q26_SAT;
                        dz_d  = 1'b1;
                    end else begin
                        res_d = sat_res;
                        dz_d  = 1'b0;
                    end
                end else if (io.result_ready) begin
                    vld_d = 1'b0;
`ifdef PI_READER_AUTO_EN
                    state_d = SEL_TOT;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tot_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tot_q   <= tot_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            dz_q    <= dz_d;
        end
    end

    assign io.sel          = (state_q == SEL_HIT) || (state_q == CAP_HIT);
    assign io.busy         = (state_q != IDLE);
    assign io.result       = res_q;
    assign io.result_valid = vld_q;
    assign io.div_zero     = dz_q;

endmodule
